// File: rtl/aes_sub_bytes_seq_pkg.sv
// Shared constants and types for the word-serial AES SubBytes block.
package aes_sub_bytes_seq_pkg;
  localparam int NUM_WORDS = 4;
  localparam int WORD_W    = 32;
  localparam int BYTE_W    = 8;
  localparam int BLOCK_W   = NUM_WORDS * WORD_W;
  localparam int NUM_LANES = WORD_W / BYTE_W;
  localparam int CNT_W     = 2;

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Packed index NUM_WORDS-1 holds word 0 (bits [127:96]).
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] block_t;
endpackage

// File: rtl/aes_sub_bytes_seq_if.sv
// Request/response bundle between a block producer and the SubBytes unit.
interface aes_sub_bytes_seq_if;
  import aes_sub_bytes_seq_pkg::*;

  logic   start;
  block_t block_in;
  logic   ready;
  block_t result;
  logic   result_valid;

  modport master (
    output start, block_in,
    input  ready, result, result_valid
  );

  modport slave (
    input  start, block_in,
    output ready, result, result_valid
  );
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, pure combinational table lookup.
module aes_sbox (
  input  logic [7:0] val,
  output logic [7:0] sub
);
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = SBOX[val];
endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Word-serial AES SubBytes: one 32-bit word per cycle through 4 S-box lanes,
// result published one cycle after the last word with a single valid pulse.
module aes_sub_bytes_seq
  import aes_sub_bytes_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  aes_sub_bytes_seq_if.slave  bus
);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] widx;
  block_t           work, work_nxt, result_q;
  logic [WORD_W-1:0] cur_word, sub_word;
  logic             accept, last;

  // DONE accepts like IDLE so back-to-back blocks cost 5 cycles.
  assign accept = (state != BUSY) && bus.start;
  assign last   = (state == BUSY) && (cnt == LAST_WORD);

  // Word 0 lives at the top packed index.
  assign widx     = LAST_WORD - cnt;
  assign cur_word = work[widx];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .val (cur_word[g*BYTE_W +: BYTE_W]),
      .sub (sub_word[g*BYTE_W +: BYTE_W])
    );
  end

  // Work register with the current word replaced by its substitution.
  always_comb begin
    work_nxt       = work;
    work_nxt[widx] = sub_word;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = BUSY;
      BUSY:    if (cnt == LAST_WORD) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Capture on accept, then substitute one word per BUSY cycle in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work <= '0;
      cnt  <= '0;
    end else if (accept) begin
      work <= bus.block_in;
      cnt  <= '0;
    end else if (state == BUSY) begin
      work <= work_nxt;
      if (!last) cnt <= cnt + 1'b1;
    end
  end

  // Result only ever takes a fully substituted block, including the last word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  result_q <= '0;
    else if (last) result_q <= work_nxt;
  end

  assign bus.ready        = (state != BUSY);
  assign bus.result_valid = (state == DONE);
  assign bus.result       = result_q;
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Self-checking bench: GF(2^8) derived S-box model, transaction-level
// expectation model, per-cycle compare, plus directed literal checks.
module tb_aes_sub_bytes_seq;
  logic clk = 1'b0;
  logic reset_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   pulses = 0;

  aes_sub_bytes_seq_if bus();

  aes_sub_bytes_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] sbox_m [0:255];
  logic [7:0] inv_m  [0:255];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] sub_block(input logic [127:0] b);
    logic [127:0] o;
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = sbox_m[b[127-8*j -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_block(input logic [127:0] b);
    logic [127:0] o;
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = inv_m[b[127-8*j -: 8]];
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model: a block accepted while idle completes 4 edges later.
  logic         m_ready = 1'b1;
  logic         m_valid = 1'b0;
  logic [127:0] m_result = '0;
  logic         pend = 1'b0;
  logic [127:0] pend_blk = '0;
  int           pend_done = 0;
  int           cyc = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend = 1'b0; m_ready = 1'b1; m_valid = 1'b0; m_result = '0;
    end else begin
      logic rdy;
      cyc++;
      rdy = !pend;
      m_valid = 1'b0;
      if (pend && cyc == pend_done) begin
        m_result = sub_block(pend_blk);
        m_valid = 1'b1;
        pend = 1'b0;
      end
      if (rdy && bus.start) begin
        pend = 1'b1;
        pend_blk = bus.block_in;
        pend_done = cyc + 4;
      end
      m_ready = !pend;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    check("ready", 128'(bus.ready), 128'(m_ready));
    check("result_valid", 128'(bus.result_valid), 128'(m_valid));
    check("result", bus.result, m_result);
    if (bus.result_valid) pulses++;
  end

  task automatic run_block(input logic [127:0] b, input logic ones_mid, output logic [127:0] r);
    int lat;
    bit got;
    bus.start = 1'b1;
    bus.block_in = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (ones_mid) bus.block_in = '1;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (bus.result_valid) got = 1'b1;
    end
    r = bus.result;
    check("latency", 128'(lat), 128'd5);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] r, b;
    int p0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.block_in = '0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_m[x] = s;
      inv_m[s] = 8'(x);
    end
    check("model_00", 128'(sbox_m[8'h00]), 128'h63);
    check("model_53", 128'(sbox_m[8'h53]), 128'hed);
    check("model_ff", 128'(sbox_m[8'hff]), 128'h16);
    check("model_vec", sub_block(128'h00112233_44556677_8899aabb_ccddeeff),
          128'h638293c3_1bfc33f5_c4eeacea_4bc12816);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(bus.ready), 128'd1);
    check("rst_valid", 128'(bus.result_valid), 128'd0);
    check("rst_result", bus.result, 128'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_block(128'h0, 1'b0, r);
    check("zero_block", r, {16{8'h63}});
    run_block(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, r);
    check("fips_vec", r, 128'h638293c3_1bfc33f5_c4eeacea_4bc12816);
    run_block({16{8'h53}}, 1'b1, r);
    check("busy_change", r, {16{8'hed}});

    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) b[127-8*j -: 8] = 8'(16*k + j);
      run_block(b, 1'b0, r);
      check("sweep", r, sub_block(b));
      check("roundtrip", inv_block(r), b);
    end

    p0 = pulses;
    bus.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.block_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("stream_pulses", 128'(pulses - p0), 128'd4);

    bus.start = 1'b1;
    bus.block_in = 128'hdeadbeef_01234567_89abcdef_feedface;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("abort_ready", 128'(bus.ready), 128'd1);
    check("abort_valid", 128'(bus.result_valid), 128'd0);
    check("abort_result", bus.result, 128'd0);
    p0 = pulses;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_pulse", 128'(pulses - p0), 128'd0);
    run_block(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, r);
    check("after_abort", r, 128'h638293c3_1bfc33f5_c4eeacea_4bc12816);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
